// File: rtl/ceyloniac_mem_pkg.sv
// Shared definitions for the Ceyloniac memory-access controller.
package ceyloniac_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR
    } state_t;

    // Misaligned half/word or the reserved size code.
    function automatic logic request_invalid(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return (addr_lo != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

    // Little-endian lane enables for an aligned access.
    function automatic logic [NUM_LANES-1:0] lane_enables(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    // Replicate low-aligned store data so every enabled lane sees the right bytes.
    function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SIZE_BYTE: return {4{d[7:0]}};
            SIZE_HALF: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/ceyloniac_load_align.sv
// Selects the addressed lane of a RAM read word and sign/zero-extends it.
module ceyloniac_load_align
    import ceyloniac_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension according to size and signedness.
    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SIZE_BYTE: o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SIZE_HALF: o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:   o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/ceyloniac_mem_access_ctrl.sv
// Single-outstanding load/store controller: req/ack RAM handshake with timeout,
// byte-enable generation and load data alignment. All outputs are registered.
module ceyloniac_mem_access_ctrl
    import ceyloniac_mem_pkg::*;
#(
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [1:0]                cpu_size,
    input  logic                      cpu_unsigned,
    input  logic [RAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [RAM_DATA_WIDTH-1:0] cpu_write_data,
    output logic                      cpu_busy,
    output logic                      cpu_done,
    output logic                      cpu_err,
    output logic [RAM_DATA_WIDTH-1:0] mem_read_data,
    output logic                      ram_req,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-3:0] ram_addr,
    output logic [NUM_LANES-1:0]      ram_byte_en,
    output logic [RAM_DATA_WIDTH-1:0] ram_write_data,
    input  logic [RAM_DATA_WIDTH-1:0] ram_read_data,
    input  logic                      ram_ack
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                    r_state;
    state_t                    w_next;

    logic                      r_we;
    logic [1:0]                r_size;
    logic [1:0]                r_addr_lo;
    logic                      r_unsigned;
    logic [CNT_W-1:0]          r_cnt;

    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic [RAM_DATA_WIDTH-1:0] r_rd_data;
    logic                      r_ram_req;
    logic                      r_ram_we;
    logic [RAM_ADDR_WIDTH-3:0] r_ram_addr;
    logic [NUM_LANES-1:0]      r_ram_be;
    logic [RAM_DATA_WIDTH-1:0] r_ram_wdata;

    logic                      w_bad;
    logic                      w_ack;
    logic                      w_timeout;
    logic [RAM_DATA_WIDTH-1:0] w_load_data;

    assign w_bad     = request_invalid(cpu_size, cpu_addr[1:0]);
    assign w_ack     = (r_state == ST_REQ) && ram_ack;
    assign w_timeout = (r_state == ST_REQ) && !ram_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    ceyloniac_load_align u_load_align (
        .i_rdata    (ram_read_data),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; ack takes priority over timeout in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (cpu_req) w_next = w_bad ? ST_ERR : ST_REQ;
            ST_REQ: begin
                if (w_ack)          w_next = ST_DONE;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request attribute latch and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_size     <= '0;
            r_addr_lo  <= '0;
            r_unsigned <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (r_state == ST_IDLE && cpu_req) begin
                r_we       <= cpu_we;
                r_size     <= cpu_size;
                r_addr_lo  <= cpu_addr[1:0];
                r_unsigned <= cpu_unsigned;
            end
            if (r_state == ST_REQ && !ram_ack) r_cnt <= r_cnt + CNT_W'(1);
            else                               r_cnt <= '0;
        end
    end

    // Registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_data   <= '0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_be    <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE) || (w_next == ST_ERR);
            r_err  <= (w_next == ST_ERR);
            if (r_state == ST_IDLE && w_next == ST_REQ) begin
                r_ram_req   <= 1'b1;
                r_ram_we    <= cpu_we;
                r_ram_addr  <= cpu_addr[RAM_ADDR_WIDTH-1:2];
                r_ram_be    <= lane_enables(cpu_size, cpu_addr[1:0]);
                r_ram_wdata <= replicate_store(cpu_size, cpu_write_data);
            end else if (r_state == ST_REQ && w_next != ST_REQ) begin
                r_ram_req   <= 1'b0;
                r_ram_we    <= 1'b0;
                r_ram_addr  <= '0;
                r_ram_be    <= '0;
                r_ram_wdata <= '0;
            end
            if (w_ack && !r_we) r_rd_data <= w_load_data;
        end
    end

    assign cpu_busy       = r_busy;
    assign cpu_done       = r_done;
    assign cpu_err        = r_err;
    assign mem_read_data  = r_rd_data;
    assign ram_req        = r_ram_req;
    assign ram_we         = r_ram_we;
    assign ram_addr       = r_ram_addr;
    assign ram_byte_en    = r_ram_be;
    assign ram_write_data = r_ram_wdata;

endmodule

// File: tb/tb_ceyloniac_mem_access_ctrl.sv
// Self-checking bench for ceyloniac_mem_access_ctrl: directed cases plus random accesses.
module tb_ceyloniac_mem_access_ctrl;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] mem_read_data;
    logic        ram_req;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_byte_en;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ack;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    ceyloniac_mem_access_ctrl #(
        .RAM_DATA_WIDTH (32),
        .RAM_ADDR_WIDTH (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_size       (cpu_size),
        .cpu_unsigned   (cpu_unsigned),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_busy       (cpu_busy),
        .cpu_done       (cpu_done),
        .cpu_err        (cpu_err),
        .mem_read_data  (mem_read_data),
        .ram_req        (ram_req),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_byte_en    (ram_byte_en),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .ram_ack        (ram_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(cpu_busy), 32'd0);
        chk({tag, "_done"}, 32'(cpu_done), 32'd0);
        chk({tag, "_err"},  32'(cpu_err), 32'd0);
        chk({tag, "_rd"},   mem_read_data, 32'd0);
        chk({tag, "_req"},  32'(ram_req), 32'd0);
        chk({tag, "_we"},   32'(ram_we), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_be"},   32'(ram_byte_en), 32'd0);
        chk({tag, "_wd"},   ram_write_data, 32'd0);
    endtask

    // Reference load formatting: shift the word down, keep the access width, extend.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] lo,
                                             input logic [1:0] size, input logic uns);
        int unsigned bits;
        logic [31:0] mask;
        logic [31:0] v;
        bits = 8 << size;
        if (bits >= 32) return rd;
        mask = (32'd1 << bits) - 32'd1;
        v = (rd >> (8 * lo)) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // Drive one access from an IDLE cycle and check it cycle by cycle until the next IDLE cycle.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_at, input int rst_at);
        bit          bad;
        int unsigned nb;
        logic [3:0]  be;
        logic [31:0] wexp;
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
        cpu_addr = addr; cpu_write_data = wd;
        chk("idle_busy", 32'(cpu_busy), 32'd0);
        bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        tick();
        cpu_req = 1'($urandom); cpu_addr = $urandom; cpu_size = 2'($urandom);
        cpu_we = 1'($urandom); cpu_write_data = $urandom;
        if (bad) begin
            chk("err_done", 32'(cpu_done), 32'd1);
            chk("err_err",  32'(cpu_err), 32'd1);
            chk("err_req",  32'(ram_req), 32'd0);
            chk("err_busy", 32'(cpu_busy), 32'd1);
            chk("err_rd",   mem_read_data, exp_rd);
            tick();
            cpu_req = 1'b0;
            chk("err_after_done", 32'(cpu_done), 32'd0);
            chk("err_after_busy", 32'(cpu_busy), 32'd0);
            return;
        end
        nb = 1 << size;
        be = 4'(((32'd1 << nb) - 32'd1) << addr[1:0]);
        case (nb)
            1:       wexp = (wd & 32'hFF) * 32'h0101_0101;
            2:       wexp = (wd & 32'hFFFF) * 32'h0001_0001;
            default: wexp = wd;
        endcase
        for (int k = 0; k < int'(TO); k++) begin
            ram_read_data = $urandom;
            chk("req_req",  32'(ram_req), 32'd1);
            chk("req_we",   32'(ram_we), 32'(we));
            chk("req_addr", 32'(ram_addr), addr >> 2);
            chk("req_be",   32'(ram_byte_en), 32'(be));
            chk("req_wd",   ram_write_data, wexp);
            chk("req_done", 32'(cpu_done), 32'd0);
            chk("req_busy", 32'(cpu_busy), 32'd1);
            chk("req_rd",   mem_read_data, exp_rd);
            if (k == rst_at) begin
                reset = 1'b1;
                cpu_req = 1'b0;
                #1;
                exp_rd = '0;
                chk_zero("rst_async");
                tick();
                chk_zero("rst_held");
                reset = 1'b0;
                tick();
                chk_zero("rst_after");
                return;
            end
            if (k == ack_at) begin
                ram_ack = 1'b1;
                ram_read_data = rd;
                tick();
                ram_ack = 1'b0;
                ram_read_data = $urandom;
                if (!we) exp_rd = ref_load(rd, addr[1:0], size, uns);
                chk("ok_done", 32'(cpu_done), 32'd1);
                chk("ok_err",  32'(cpu_err), 32'd0);
                chk("ok_req",  32'(ram_req), 32'd0);
                chk("ok_busy", 32'(cpu_busy), 32'd1);
                chk("ok_rd",   mem_read_data, exp_rd);
                tick();
                cpu_req = 1'b0;
                chk("ok_after_done", 32'(cpu_done), 32'd0);
                chk("ok_after_busy", 32'(cpu_busy), 32'd0);
                chk("ok_after_rd",   mem_read_data, exp_rd);
                return;
            end
            tick();
        end
        chk("to_done", 32'(cpu_done), 32'd1);
        chk("to_err",  32'(cpu_err), 32'd1);
        chk("to_req",  32'(ram_req), 32'd0);
        ram_ack = 1'b1;
        ram_read_data = $urandom;
        cpu_req = 1'b0;
        tick();
        chk("late_done", 32'(cpu_done), 32'd0);
        chk("late_busy", 32'(cpu_busy), 32'd0);
        tick();
        ram_ack = 1'b0;
        chk("late_req",  32'(ram_req), 32'd0);
        chk("late_done2", 32'(cpu_done), 32'd0);
        chk("late_rd",   mem_read_data, exp_rd);
    endtask

    initial begin
        logic [1:0]  rsize;
        logic [31:0] raddr;
        int          rack;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_unsigned = 1'b0;
        cpu_addr = '0; cpu_write_data = '0; ram_read_data = '0; ram_ack = 1'b0;
        exp_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        tick();

        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, -1);
        chk("word_load", mem_read_data, 32'hDEAD_BEEF);
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FF_0000, 0, -1);
        chk("byte_signed", mem_read_data, 32'hFFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FF_0000, 1, -1);
        chk("byte_unsigned", mem_read_data, 32'h0000_0080);
        access(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 2, -1);
        chk("store_keeps_rd", mem_read_data, 32'h0000_0080);
        access(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 32'h0, 0, -1);
        access(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 0, -1);
        access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, -1, -1);
        access(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'h1234_5678, 5, 2);
        access(1'b0, 2'd1, 1'b0, 32'h46, 32'h0, 32'h8001_0000, 0, -1);
        chk("fresh_half", mem_read_data, 32'hFFFF_8001);

        for (int i = 0; i < 40; i++) begin
            rsize = 2'($urandom);
            raddr = $urandom;
            if ($urandom_range(3) != 0) begin
                if (rsize == 2'd1) raddr[0] = 1'b0;
                if (rsize == 2'd2) raddr[1:0] = 2'd0;
            end
            rack = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(3));
            access(1'($urandom), rsize, 1'($urandom), raddr, $urandom, $urandom, rack, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
